// File: rtl/rdid_spi_master.sv
// RDID (JEDEC ID) reader for SPI NOR flash, SPI mode 0.
// One start pulse shifts out the 0x9F instruction, then clocks in the 3-byte ID
// (manufacturer, memory type, capacity). The ID is presented on id_data with a done pulse.
module rdid_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [7:0]  CMD     = 8'h9F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        miso,
  output logic        sck,
  output logic        cs_n,
  output logic        mosi,
  output logic        busy,
  output logic        done,
  output logic [23:0] id_data
);

  // Terminal count of the half-period counter; 8 bits covers CLK_DIV up to 255.
  localparam logic [7:0] DivM1    = 8'(CLK_DIV - 1);
  localparam logic [5:0] NumBits  = 6'd32;
  localparam logic [5:0] CmdBits  = 6'd8;

  typedef enum logic [1:0] {
    StIdle,
    StCsSetup,
    StShift,
    StCsHold
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;     // cycles elapsed in the current phase
  logic [5:0]  bit_q, bit_d;     // completed bits (falling edges seen), 0..32
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  tx_q, tx_d;       // remaining command bits, next bit in [7]
  logic [23:0] rx_q, rx_d;       // response shift register
  logic [23:0] id_q, id_d;

  // Next-state and output logic for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_d    = tx_q;
    rx_d    = rx_q;
    id_d    = id_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCsSetup;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = CMD[7];
          tx_d    = {CMD[6:0], 1'b0};
          cnt_d   = 8'd0;
          bit_d   = 6'd0;
          rx_d    = 24'h0;
        end
      end

      StCsSetup: begin
        if (cnt_q == DivM1) begin
          // First rising edge; the flash is still receiving the command, sample is dropped.
          cnt_d   = 8'd0;
          sck_d   = 1'b1;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StShift: begin
        if (cnt_q != DivM1) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (sck_q) begin
            // Falling edge: present the next command bit (zeros once the command is out).
            sck_d  = 1'b0;
            mosi_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
            bit_d  = bit_q + 6'd1;
          end else if (bit_q == NumBits) begin
            // Low phase of the last bit has elapsed.
            state_d = StCsHold;
          end else begin
            // Rising edge: sample miso for response bits only.
            sck_d = 1'b1;
            if (bit_q >= CmdBits) begin
              rx_d = {rx_q[22:0], miso};
            end
          end
        end
      end

      StCsHold: begin
        if (cnt_q == DivM1) begin
          cnt_d   = 8'd0;
          state_d = StIdle;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          id_d    = rx_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      bit_q   <= 6'd0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 8'h0;
      rx_q    <= 24'h0;
      id_q    <= 24'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      id_q    <= id_d;
    end
  end

  assign sck     = sck_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign id_data = id_q;

endmodule

// File: tb/tb_rdid_spi_master.sv
// Bench for rdid_spi_master: two instances (CLK_DIV=4 and CLK_DIV=1), each attached to a
// behavioural SPI flash that answers RDID with a programmable ID.
module tb_rdid_spi_master;

  localparam int unsigned Div0 = 4;
  localparam int unsigned Div1 = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start   [2];
  logic        miso    [2];
  logic        sck     [2];
  logic        cs_n    [2];
  logic        mosi    [2];
  logic        busy    [2];
  logic        done    [2];
  logic [23:0] id_data [2];
  logic [23:0] model_id [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic rst_at_edge = 1'b0;

  always #5 clk = ~clk;

  rdid_spi_master #(.CLK_DIV(Div0), .CMD(8'h9F)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .miso(miso[0]), .sck(sck[0]),
    .cs_n(cs_n[0]), .mosi(mosi[0]), .busy(busy[0]), .done(done[0]), .id_data(id_data[0])
  );

  rdid_spi_master #(.CLK_DIV(Div1), .CMD(8'h9F)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .miso(miso[1]), .sck(sck[1]),
    .cs_n(cs_n[1]), .mosi(mosi[1]), .busy(busy[1]), .done(done[1]), .id_data(id_data[1])
  );

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
  end

  // Flash response: bit n of the 32-bit frame; command-phase bits are junk.
  function automatic logic resp_bit(input logic [23:0] id, input int n);
    if (n < 8) return 1'($urandom_range(0, 1));
    if (n < 32) return id[31-n];
    return 1'b0;
  endfunction

  // Flash model: counts sck rises while selected, changes miso on sck falls (mode 0).
  int   fcnt      [2] = '{0, 0};
  logic f_prev_sck[2] = '{1'b0, 1'b0};
  logic f_prev_cs [2] = '{1'b1, 1'b1};
  always @(sck[0], sck[1], cs_n[0], cs_n[1]) begin
    for (int g = 0; g < 2; g++) begin
      if (cs_n[g] !== 1'b0) begin
        fcnt[g] = 0;
      end else if (f_prev_cs[g] === 1'b1) begin
        miso[g] = resp_bit(model_id[g], 0);
      end else if (f_prev_sck[g] === 1'b0 && sck[g] === 1'b1) begin
        fcnt[g] = fcnt[g] + 1;
      end else if (f_prev_sck[g] === 1'b1 && sck[g] === 1'b0) begin
        miso[g] = resp_bit(model_id[g], fcnt[g]);
      end
      f_prev_sck[g] = sck[g];
      f_prev_cs[g]  = cs_n[g];
    end
  end

  // Bus monitor: cumulative counters sampled mid-cycle.
  int         rises    [2] = '{0, 0};
  int         rise_txn [2] = '{0, 0};
  logic [7:0] cmd_sh   [2] = '{8'h0, 8'h0};
  int         mosi_err [2] = '{0, 0};
  int         low_cnt  [2] = '{0, 0};
  int         done_cnt [2] = '{0, 0};
  int         done_cyc [2] = '{0, 0};
  logic       done_cs  [2] = '{1'b0, 1'b0};
  logic       done_busy[2] = '{1'b0, 1'b0};
  int         hold_err [2] = '{0, 0};
  logic       m_prev_sck[2] = '{1'b0, 1'b0};
  logic [23:0] id_prev [2] = '{24'h0, 24'h0};
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (cs_n[g] === 1'b1) rise_txn[g] = 0;
      if (sck[g] === 1'b1 && m_prev_sck[g] === 1'b0) begin
        if (rise_txn[g] < 8) cmd_sh[g] = {cmd_sh[g][6:0], mosi[g]};
        else if (mosi[g] !== 1'b0) mosi_err[g] = mosi_err[g] + 1;
        rises[g]    = rises[g] + 1;
        rise_txn[g] = rise_txn[g] + 1;
      end
      m_prev_sck[g] = sck[g];
      if (cs_n[g] === 1'b0) low_cnt[g] = low_cnt[g] + 1;
      if (done[g] === 1'b1) begin
        done_cnt[g]  = done_cnt[g] + 1;
        done_cyc[g]  = cyc;
        done_cs[g]   = cs_n[g];
        done_busy[g] = busy[g];
      end
      if (id_data[g] !== id_prev[g] && done[g] !== 1'b1 && !rst_at_edge)
        hold_err[g] = hold_err[g] + 1;
      id_prev[g] = id_data[g];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next falling clock edge so monitor updates are settled.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One RDID transaction on instance g; optional second start at E0+lock_at.
  task automatic run_txn(input int g, input logic [23:0] id, input int lock_at);
    int d = (g == 0) ? Div0 : Div1;
    int r0 = rises[g];
    int d0 = done_cnt[g];
    int l0 = low_cnt[g];
    int m0 = mosi_err[g];
    int h0 = hold_err[g];
    int e0;
    int n = 0;
    model_id[g] = id;
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
    e0 = cyc;
    while (done_cnt[g] == d0 && n < 66 * d + 50) begin
      start[g] = (lock_at != 0) && (cyc - e0 + 1 == lock_at);
      tick();
      n++;
    end
    start[g] = 1'b0;
    check_eq($sformatf("done_count[%0d]", g), done_cnt[g] - d0, 1);
    check_eq($sformatf("done_latency[%0d]", g), done_cyc[g] - e0, 66 * d);
    check_eq($sformatf("id_data[%0d]", g), id_data[g], id);
    check_eq($sformatf("sck_rises[%0d]", g), rises[g] - r0, 32);
    check_eq($sformatf("mosi_cmd[%0d]", g), cmd_sh[g], 8'h9F);
    check_eq($sformatf("mosi_resp_zero[%0d]", g), mosi_err[g] - m0, 0);
    check_eq($sformatf("cs_low_cycles[%0d]", g), low_cnt[g] - l0, 66 * d);
    check_eq($sformatf("cs_n_at_done[%0d]", g), done_cs[g], 1);
    check_eq($sformatf("busy_at_done[%0d]", g), done_busy[g], 0);
    check_eq($sformatf("id_hold[%0d]", g), hold_err[g] - h0, 0);
  endtask

  initial begin
    int e0;
    int d0;
    int viol;
    reset       = 1'b1;
    start[0]    = 1'b0;
    start[1]    = 1'b0;
    model_id[0] = 24'h0;
    model_id[1] = 24'h0;
    repeat (3) tick();

    // Reset values.
    check_eq("rst_sck", sck[0], 0);
    check_eq("rst_cs_n", cs_n[0], 1);
    check_eq("rst_mosi", mosi[0], 0);
    check_eq("rst_busy", busy[0], 0);
    check_eq("rst_done", done[0], 0);
    check_eq("rst_id", id_data[0], 24'h0);
    reset = 1'b0;

    // Idle: nothing moves without a start.
    d0   = done_cnt[0] + done_cnt[1];
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      for (int g = 0; g < 2; g++)
        if (sck[g] !== 1'b0 || cs_n[g] !== 1'b1 || mosi[g] !== 1'b0 || done[g] !== 1'b0)
          viol++;
    end
    check_eq("idle_bus", viol, 0);
    check_eq("idle_done", done_cnt[0] + done_cnt[1] - d0, 0);

    // Nominal, then a start while busy that must be ignored.
    run_txn(0, 24'h20BA18, 0);
    repeat (3) tick();
    run_txn(0, 24'h20BA18, 50);

    // Reset in the middle of a transaction.
    repeat (2) tick();
    model_id[0] = 24'h20BA18;
    d0 = done_cnt[0];
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    e0 = cyc;
    while (cyc < e0 + 99) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_cs_n", cs_n[0], 1);
    check_eq("midrst_sck", sck[0], 0);
    check_eq("midrst_busy", busy[0], 0);
    check_eq("midrst_id", id_data[0], 24'h0);
    repeat (300) tick();
    check_eq("midrst_no_done", done_cnt[0] - d0, 0);
    run_txn(0, 24'h20BA18, 0);

    // Back-to-back: second start on the cycle after done.
    run_txn(0, 24'hEF4017, 0);

    // Minimum divider.
    run_txn(1, 24'hC22016, 0);

    // Randomised IDs and gaps on both instances.
    for (int i = 0; i < 6; i++) begin
      int g = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 20)) tick();
      run_txn(g, 24'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rdid_spi_master.md
Name: rdid_spi_master

Overview:
Issues the SPI flash RDID instruction (0x9F) and captures the 3-byte JEDEC ID response (manufacturer, memory type, capacity). Triggered by the single-cycle pulse that the button one-shot produces from the debounced get_rdid input. Drives SCK, CS_N and MOSI to the flash in SPI mode 0, and presents the captured ID to the display/LED logic.

Parameters:
CLK_DIV, 4, SCK half-period in clk cycles; legal range 1..255; SCK period = 2*CLK_DIV clk cycles
CMD, 8'h9F, instruction byte shifted out MSB first

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
start  input  1  single-cycle request pulse (one-shot output)
miso  input  1  flash serial data out
sck  output  1  SPI clock, idles low
cs_n  output  1  flash chip select, active-low
mosi  output  1  flash serial data in
busy  output  1  high while a transaction is in progress
done  output  1  one-cycle pulse when id_data is updated
id_data  output  24  captured ID, first received byte in [23:16]

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Values at reset: sck=0, cs_n=1, mosi=0, busy=0, done=0, id_data=24'h0. The FSM goes to IDLE. All internal counters clear.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD.
- IDLE:
  - start=1 at clock edge E0 moves the FSM to CS_SETUP.
  - At E0: cs_n goes low, busy goes high, mosi = CMD[7].
  - start is ignored in every other state. There is no queuing.
- CS_SETUP:
  - Lasts CLK_DIV cycles with sck low, then moves to SHIFT.
- SHIFT: 32 bits in total, 8 command bits then 24 response bits.
  - Each bit is a high phase of CLK_DIV cycles followed by a low phase of CLK_DIV cycles.
  - miso is sampled on the clk edge where sck goes 0->1. It shifts into a 24-bit register, MSB first, for bits 8..31 only. Samples from bits 0..7 are discarded.
  - mosi updates on the clk edge where sck goes 1->0.
  - mosi carries CMD bits 6..0 for bits 1..7, then is held 0 for bits 8..31.
  - After the 32nd falling edge, the FSM moves to CS_HOLD. sck stays low.
- CS_HOLD:
  - Lasts CLK_DIV cycles.
  - On the final edge: cs_n=1, busy=0, done=1 for one cycle, and id_data loads the shift register. The FSM returns to IDLE.
- Timing and edge counts:
  - done is asserted exactly at edge E0 + 66*CLK_DIV (264 cycles for CLK_DIV=4).
  - cs_n stays low for exactly 66*CLK_DIV cycles.
  - Exactly 32 sck rising edges occur per transaction.
- Holding and back-to-back behaviour:
  - id_data holds its value between transactions. It changes only on done.
  - A start coincident with done is ignored, because the FSM is not yet in IDLE.
  - A start in the cycle after done is accepted.
- Reset mid-transaction: on the next edge cs_n=1 and sck=0, the FSM goes to IDLE, id_data=0, and no done pulse is generated.
- Bit and cycle counters must be sized for CLK_DIV=255 and 32 bits without wrap.

Test Plan:
- Nominal: flash model returns 0x20,0xBA,0x18, CLK_DIV=4, start pulse → MOSI byte captured 0x9F; 32 sck rises; done at E0+264; id_data=24'h20BA18; cs_n high and busy low on the same edge.
- Busy lockout: second start at E0+50 → still one transaction only; done once; cs_n low 264 cycles; id_data=24'h20BA18.
- Reset mid-op: reset at E0+100 for 1 cycle → next edge cs_n=1, sck=0, busy=0, id_data=0; no done; a later start completes normally with 0x20BA18.
- Back-to-back: model changes ID to 0xEF4017, start issued the cycle after the first done → second transaction runs; id_data goes 0x20BA18 → 0xEF4017 only at the second done.
- Minimum divider: CLK_DIV=1, model returns 0xC22016 → sck toggles every cycle; done at E0+66; id_data=24'h C22016; mosi=0 during all response bits.
- Idle check: no start for 1000 cycles after reset → sck=0, cs_n=1, mosi=0, done never asserted.
